// File: rtl/seq_detector_param.sv
// ---------------------------------------------------------------------------
// seq_detector_param
//   Serial pattern detector with a registered, Moore-style match flag.
//   The pattern is loadable at runtime. Matches may overlap or not. Input
//   beats are qualified by a valid strobe, and matches are counted in a
//   saturating counter.
//
//   Optional build macro: SEQ_DET_MASK_EN
//     When defined, this adds mask_in. mask_in is captured on load, and its
//     reset value is all ones. Pattern bits whose mask bit is 0 are
//     don't-care in the compare. Without the macro, the compare is exact.
//
//   Ports
//     clock           rising-edge clock
//     reset_n         asynchronous active-low reset
//     enable          detector enable (0 forces IDLE)
//     load            write pattern_in (and mask_in) into the pattern register
//     pattern_in      new pattern, MSB is the first bit received
//     mask_in         per-bit compare mask (SEQ_DET_MASK_EN builds only)
//     overlap         1 = overlapping matches, 0 = non-overlapping
//     sequence_valid  sequence_in carries a beat this cycle
//     sequence_in     serial data bit
//     count_clear     synchronous clear of match_count
//     detector_out    high for each cycle spent in MATCH
//     match_count     saturating number of matches
//     armed           high in HUNT or MATCH
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | detector disabled; beats ignored; history and fill held at 0
//   HUNT  | shifting beats in and comparing against the pattern
//   MATCH | previous beat completed a match; detector_out is high
// ---------------------------------------------------------------------------
module seq_detector_param #(
  parameter int                     PATTERN_LEN     = 4,
  parameter logic [PATTERN_LEN-1:0] DEFAULT_PATTERN = PATTERN_LEN'(4'b1011),
  parameter int                     CNT_W           = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   load,
  input  logic [PATTERN_LEN-1:0] pattern_in,
`ifdef SEQ_DET_MASK_EN
  input  logic [PATTERN_LEN-1:0] mask_in,
`endif
  input  logic                   overlap,
  input  logic                   sequence_valid,
  input  logic                   sequence_in,
  input  logic                   count_clear,
  output logic                   detector_out,
  output logic [CNT_W-1:0]       match_count,
  output logic                   armed
);

  // fill counts received beats up to PATTERN_LEN, so it needs to hold that value.
  localparam int FW = $clog2(PATTERN_LEN + 1);
  localparam logic [FW-1:0] LEN_F = FW'(PATTERN_LEN);
  localparam logic [FW:0]   LEN_X = (FW+1)'(PATTERN_LEN);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HUNT  = 2'd1,
    MATCH = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [PATTERN_LEN-1:0] pattern_q, pattern_d;
  logic [PATTERN_LEN-1:0] history_q, history_d;
  logic [FW-1:0]          fill_q, fill_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   match_evt;

  logic [PATTERN_LEN-1:0] shifted;
  logic [FW:0]            fill_inc;
  logic [FW-1:0]          fill_sat;
  logic                   fill_full;
  logic                   pattern_hit;

  assign shifted   = {history_q[PATTERN_LEN-2:0], sequence_in};
  assign fill_inc  = (FW+1)'(fill_q) + (FW+1)'(1);
  assign fill_full = (fill_inc >= LEN_X);
  assign fill_sat  = fill_full ? LEN_F : fill_inc[FW-1:0];

`ifdef SEQ_DET_MASK_EN
  logic [PATTERN_LEN-1:0] mask_q, mask_d;

  assign pattern_hit = (((shifted ^ pattern_q) & mask_q) == '0);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_q <= '1;
    end else begin
      mask_q <= mask_d;
    end
  end

  always_comb begin
    mask_d = mask_q;
    if (load) begin
      mask_d = mask_in;
    end
  end
`else
  assign pattern_hit = (shifted == pattern_q);
`endif

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      pattern_q <= DEFAULT_PATTERN;
      history_q <= '0;
      fill_q    <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pattern_q <= pattern_d;
      history_q <= history_d;
      fill_q    <= fill_d;
      count_q   <= count_d;
    end
  end

  // The pattern write on load happens even with enable low. Only the
  // state/history path gives enable priority over load.
  always_comb begin
    state_d   = state_q;
    pattern_d = pattern_q;
    history_d = history_q;
    fill_d    = fill_q;
    match_evt = 1'b0;

    if (load) begin
      pattern_d = pattern_in;
    end

    if (!enable) begin
      state_d   = IDLE;
      history_d = '0;
      fill_d    = '0;
    end else if (load) begin
      // A beat that arrives in the same cycle as a load is discarded.
      state_d   = HUNT;
      history_d = '0;
      fill_d    = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d   = HUNT;
          history_d = '0;
          fill_d    = '0;
        end
        HUNT, MATCH: begin
          // A bubble leaves history untouched. MATCH still falls back to HUNT.
          state_d = HUNT;
          if (sequence_valid) begin
            history_d = shifted;
            fill_d    = fill_sat;
            if (pattern_hit && fill_full) begin
              state_d   = MATCH;
              match_evt = 1'b1;
              if (!overlap) begin
                fill_d = '0;
              end
            end
          end
        end
        default: begin
          state_d   = IDLE;
          history_d = '0;
          fill_d    = '0;
        end
      endcase
    end
  end

  // The counter updates on the same edge that enters or holds MATCH, so it
  // lines up with detector_out.
  always_comb begin
    count_d = count_q;
    if (count_clear) begin
      count_d = match_evt ? CNT_W'(1) : '0;
    end else if (match_evt && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  assign detector_out = (state_q == MATCH);
  assign armed        = (state_q == HUNT) || (state_q == MATCH);
  assign match_count  = count_q;

endmodule

// File: tb/tb_seq_detector_param.sv
// ---------------------------------------------------------------------------
// tb_seq_detector_param
//   Table-driven bench for seq_detector_param. Two instances share the
//   stimulus: one with the default 8-bit counter and one with CNT_W = 2, to
//   exercise saturation. Each table row holds one cycle of inputs plus the
//   expected detector_out after that edge. The expected counter value is
//   derived from the expected flag: each MATCH cycle is one increment, with
//   saturation and clear handled separately. The expected armed value is the
//   row's enable, since any edge with enable high leaves HUNT or MATCH.
// ---------------------------------------------------------------------------
module tb_seq_detector_param;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       load;
  logic [3:0] pattern_in;
  logic       overlap;
  logic       sequence_valid;
  logic       sequence_in;
  logic       count_clear;
`ifdef SEQ_DET_MASK_EN
  logic [3:0] mask_in = 4'hF;
`endif

  logic       det8, armed8, det2, armed2;
  logic [7:0] cnt8;
  logic [1:0] cnt2;

  always #5 clock = ~clock;

  seq_detector_param dut8 (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .load           (load),
    .pattern_in     (pattern_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in        (mask_in),
`endif
    .overlap        (overlap),
    .sequence_valid (sequence_valid),
    .sequence_in    (sequence_in),
    .count_clear    (count_clear),
    .detector_out   (det8),
    .match_count    (cnt8),
    .armed          (armed8)
  );

  seq_detector_param #(.CNT_W(2)) dut2 (
    .clock          (clock),
    .reset_n        (reset_n),
    .enable         (enable),
    .load           (load),
    .pattern_in     (pattern_in),
`ifdef SEQ_DET_MASK_EN
    .mask_in        (mask_in),
`endif
    .overlap        (overlap),
    .sequence_valid (sequence_valid),
    .sequence_in    (sequence_in),
    .count_clear    (count_clear),
    .detector_out   (det2),
    .match_count    (cnt2),
    .armed          (armed2)
  );

  typedef struct {
    bit         en;
    bit         ld;
    logic [3:0] pin;
    bit         ov;
    bit         vld;
    bit         din;
    bit         clr;
    bit         exp_det;
  } vec_t;

  typedef struct {
    bit det;
    int cnt8;
    int cnt2;
    bit armed;
    int idx;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   m_cnt8 = 0;
  int   m_cnt2 = 0;

  task automatic chk(input string nm, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s row %0d: got %0d, expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic add(input bit en, input bit ld, input logic [3:0] pin, input bit ov,
                     input bit vld, input bit din, input bit clr, input bit exp_det);
    vec_t v;
    v.en = en; v.ld = ld; v.pin = pin; v.ov = ov;
    v.vld = vld; v.din = din; v.clr = clr; v.exp_det = exp_det;
    vecs.push_back(v);
  endtask

  task automatic beat(input bit ov, input bit din, input bit exp_det);
    add(1'b1, 1'b0, 4'b0000, ov, 1'b1, din, 1'b0, exp_det);
  endtask

  task automatic bubble(input bit ov);
    add(1'b1, 1'b0, 4'b0000, ov, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step(input vec_t v, input int idx);
    exp_t e;
    @(negedge clock);
    enable         = v.en;
    load           = v.ld;
    pattern_in     = v.pin;
    overlap        = v.ov;
    sequence_valid = v.vld;
    sequence_in    = v.din;
    count_clear    = v.clr;
    if (v.clr) begin
      m_cnt8 = v.exp_det ? 1 : 0;
      m_cnt2 = v.exp_det ? 1 : 0;
    end else if (v.exp_det) begin
      m_cnt8 = (m_cnt8 < 255) ? m_cnt8 + 1 : 255;
      m_cnt2 = (m_cnt2 < 3) ? m_cnt2 + 1 : 3;
    end
    e.det = v.exp_det; e.cnt8 = m_cnt8; e.cnt2 = m_cnt2; e.armed = v.en; e.idx = idx;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    chk("detector_out", e.idx, int'(det8), int'(e.det));
    chk("detector_out_w2", e.idx, int'(det2), int'(e.det));
    chk("match_count", e.idx, int'(cnt8), e.cnt8);
    chk("match_count_w2", e.idx, int'(cnt2), e.cnt2);
    chk("armed", e.idx, int'(armed8), int'(e.armed));
  endtask

  task automatic run_table(input int base);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i], base + i);
    end
    vecs.delete();
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b0; load = 1'b0; pattern_in = 4'b0000;
    overlap = 1'b1; sequence_valid = 1'b0; sequence_in = 1'b0; count_clear = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("reset_detector_out", -1, int'(det8), 0);
    chk("reset_match_count", -1, int'(cnt8), 0);
    chk("reset_armed", -1, int'(armed8), 0);
    chk("reset_match_count_w2", -1, int'(cnt2), 0);
    @(negedge clock);
    reset_n = 1'b1;

    // Default pattern 1011, overlap: 1,0,1,1,0,1,1 matches after beats 4 and 7.
    add(1, 0, 4'b0000, 1, 0, 0, 0, 0);
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 1, 0); beat(1, 1, 1);
    beat(1, 0, 0); beat(1, 1, 0); beat(1, 1, 1); bubble(1);
    // Same stream without overlap: only the first match.
    add(1, 1, 4'b1011, 0, 0, 0, 1, 0);
    beat(0, 1, 0); beat(0, 0, 0); beat(0, 1, 0); beat(0, 1, 1);
    beat(0, 0, 0); beat(0, 1, 0); beat(0, 1, 0); bubble(0);
    // Pattern 1111 with overlap: MATCH is held for three cycles.
    add(1, 1, 4'b1111, 1, 0, 0, 1, 0);
    beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 1);
    beat(1, 1, 1); beat(1, 1, 1); bubble(1);
    // Pattern 1111 without overlap: a single pulse.
    add(1, 1, 4'b1111, 0, 0, 0, 1, 0);
    beat(0, 1, 0); beat(0, 1, 0); beat(0, 1, 0); beat(0, 1, 1);
    beat(0, 1, 0); beat(0, 1, 0); bubble(0);
    // 1,0,1,1 with bubbles between the beats.
    add(1, 1, 4'b1011, 1, 0, 0, 1, 0);
    beat(1, 1, 0); bubble(1); beat(1, 0, 0); bubble(1);
    beat(1, 1, 0); bubble(1); beat(1, 1, 1); bubble(1);
    // With enable low, the load still writes the pattern; the beats are ignored.
    add(0, 1, 4'b0110, 1, 1, 1, 0, 0);
    add(0, 0, 4'b0000, 1, 1, 1, 0, 0);
    add(1, 0, 4'b0000, 1, 1, 0, 0, 0);
    beat(1, 0, 0); beat(1, 1, 0); beat(1, 1, 0); beat(1, 0, 1);
    // A load in a MATCH cycle discards the same-cycle beat.
    add(1, 1, 4'b1011, 1, 1, 1, 0, 0);
    beat(1, 0, 0); beat(1, 1, 0); beat(1, 1, 0); bubble(1);
    // Eight consecutive matches saturate the 2-bit counter; clear plus a match gives 1.
    add(1, 1, 4'b1111, 1, 0, 0, 1, 0);
    beat(1, 1, 0); beat(1, 1, 0); beat(1, 1, 0);
    for (int k = 0; k < 8; k++) beat(1, 1, 1);
    add(1, 0, 4'b0000, 1, 1, 1, 1, 1);
    bubble(1);
    // Partial 1,0,1 before the asynchronous reset pulse.
    add(1, 1, 4'b1011, 1, 0, 0, 0, 0);
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 1, 0);
    run_table(0);

    // Mid-pattern reset: the outputs drop without a clock edge.
    @(negedge clock);
    #2;
    reset_n = 1'b0;
    #1;
    chk("async_reset_detector_out", 1000, int'(det8), 0);
    chk("async_reset_match_count", 1000, int'(cnt8), 0);
    chk("async_reset_match_count_w2", 1000, int'(cnt2), 0);
    chk("async_reset_armed", 1000, int'(armed8), 0);
    m_cnt8 = 0;
    m_cnt2 = 0;
    @(negedge clock);
    reset_n = 1'b1;

    // A lone 1 after reset must not complete the old partial pattern.
    add(1, 0, 4'b0000, 1, 0, 0, 0, 0);
    beat(1, 1, 0);
    beat(1, 1, 0); beat(1, 0, 0); beat(1, 1, 0); beat(1, 1, 1);
    bubble(1);
    run_table(2000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seq_detector_param.md
Name: seq_detector_param

Overview:
Parametrised serial pattern detector with a Moore-style registered output. It is the successor to the fixed-pattern Moore sequence detector. It adds:
- runtime-loadable pattern of PATTERN_LEN bits
- overlap / non-overlap mode
- input valid qualifier
- saturating match counter

It sits on a serial bit stream and flags each completed occurrence of the pattern.

Parameters:
- PATTERN_LEN, 4, pattern length in bits (2..32).
- DEFAULT_PATTERN, 4'b1011, pattern value after reset (PATTERN_LEN bits, MSB is the first bit received).
- CNT_W, 8, match counter width.

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  detector enable
- load  in  1  load pattern_in into pattern register
- pattern_in  in  PATTERN_LEN  new pattern, MSB first-received
- overlap  in  1  1 = overlapping matches allowed, 0 = non-overlapping
- sequence_valid  in  1  sequence_in carries a beat this cycle
- sequence_in  in  1  serial data bit
- count_clear  in  1  synchronous clear of match_count
- detector_out  out  1  registered match flag
- match_count  out  CNT_W  saturating number of matches
- armed  out  1  high when state is HUNT or MATCH

Behaviour:
- Reset values (reset_n low, async): pattern = DEFAULT_PATTERN, history = 0, fill = 0, state = IDLE, detector_out = 0, match_count = 0, armed = 0.
- State IDLE:
  - entered whenever enable = 0
  - beats are ignored; history and fill are cleared
  - detector_out = 0
  - enable = 1 moves to HUNT on the next edge.
- State HUNT: a beat is a cycle with sequence_valid = 1 and load = 0.
  - Per beat: history <= {history[PATTERN_LEN-2:0], sequence_in}; fill <= min(fill+1, PATTERN_LEN).
  - Match condition on a beat: new history == pattern and fill+1 >= PATTERN_LEN. A match moves to MATCH.
- State MATCH:
  - detector_out = 1; it is a pure function of state, so it goes high the cycle after the completing beat.
  - It lasts exactly one cycle unless that cycle's beat also completes a match; in that case MATCH is held.
  - Otherwise go to HUNT.
  - Beats in MATCH are processed exactly as in HUNT.
- Overlap = 1: history and fill are kept after a match, so the suffix is reused.
- Overlap = 0: fill is cleared on the matching beat, so the next match needs PATTERN_LEN fresh beats.
- overlap is sampled per beat; a change takes effect on the next beat.
- Load:
  - load = 1 on an edge: pattern <= pattern_in; history and fill are cleared.
  - State goes to HUNT if enable = 1, else IDLE; detector_out is 0 the next cycle.
  - A beat in the same cycle is discarded. load has priority over the beat; enable = 0 has priority over load for state, but the pattern is still written.
- match_count:
  - increments by 1 on each transition into MATCH or MATCH hold, with the same timing as detector_out
  - saturates at 2^CNT_W-1
  - count_clear alone sets it to 0
  - count_clear together with a match sets it to 1
  - unaffected by load and enable.
- sequence_valid = 0 cycles are bubbles: no shift and no state change, except MATCH returns to HUNT.
- Mid-operation reset_n assertion returns all state to reset values immediately. Deassertion is synchronised by the system.

Optional Feature:
- SEQ_DET_MASK_EN defined:
  - adds input port mask_in[PATTERN_LEN-1:0], captured into a mask register on load (reset value all ones)
  - match compares only bits where mask = 1 (0 = don't-care)
  - the fill requirement is unchanged.
- Not defined: no mask port or register; full exact compare.

Test Plan:
- Reset defaults, enable = 1, overlap = 1, pattern 1011, one beat per cycle, stream 1,0,1,1,0,1,1 -> detector_out high one cycle after beat 4 and after beat 7; match_count = 2.
- Same stream with overlap = 0 -> single pulse after beat 4; match_count = 1.
- Load 1111, overlap = 1, six consecutive 1 beats -> detector_out held high for the 3 cycles after beats 4, 5 and 6; match_count = 3. With overlap = 0 -> one pulse after beat 4 only.
- Stream 1,0,1,1 with sequence_valid = 0 bubbles inserted between every beat -> single pulse one cycle after beat 4; bubbles do not shift history.
- CNT_W = 2, eight matches -> match_count stops at 3. Assert count_clear in the same cycle as the next match -> match_count = 1.
- reset_n pulsed low mid-pattern after 1,0,1 -> outputs 0 immediately; a following 1 alone gives no match; a full 1011 afterward matches.
